// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the PC fetch controller: state encoding, default
// vectors and the sequential PC increment.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0180;
  localparam logic [31:0] PC_INC        = 32'd4;

  // Redirect targets are word addresses; the low two bits are discarded.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: jump beats taken branch beats sequential pc+4.
// Redirect targets are word-aligned and a misaligned raw target is flagged.
module pc_next_sel
  import pc_fetch_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic [31:0] next_pc,
  output logic        misalign
);

  always_comb begin
    next_pc  = pc + PC_INC;
    misalign = 1'b0;
    if (jmp) begin
      next_pc  = word_align(jmp_target);
      misalign = |jmp_target[1:0];
    end else if (br_taken) begin
      next_pc  = word_align(br_target);
      misalign = |br_target[1:0];
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: sequences PC, issues memory reads and
// presents the fetched word to decode, with redirect and exception handling.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BOOT  | one idle cycle after reset, no request, exc ignored
// ST_FETCH | imem_req high at pc, waiting for imem_ack
// ST_ISSUE | instr valid for decode, held while stall is high
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        exc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic        misalign
);

  fetch_state_t state;
  logic [31:0]  next_pc;
  logic         next_misalign;

  pc_next_sel u_next_sel (
    .pc         (pc),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .next_pc    (next_pc),
    .misalign   (next_misalign)
  );

  // Gated by rst so a fetch in flight drops its request during reset.
  assign imem_req  = (state == ST_FETCH) && !rst;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BOOT;
      pc          <= RESET_VEC;
      epc         <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      misalign <= 1'b0;
      if (exc && state != ST_BOOT) begin
        // An ack landing in this cycle belongs to the aborted fetch.
        epc         <= pc;
        pc          <= EXC_VEC;
        instr_valid <= 1'b0;
        state       <= ST_FETCH;
      end else begin
        case (state)
          ST_BOOT: state <= ST_FETCH;
          ST_FETCH: begin
            if (imem_ack) begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              state       <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (!stall) begin
              pc          <= next_pc;
              misalign    <= next_misalign;
              instr_valid <= 1'b0;
              state       <= ST_FETCH;
            end
          end
          default: state <= ST_BOOT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed vector bench for pc_fetch_ctrl plus hand-written multi-cycle sequences.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, jmp, exc, imem_ack;
  logic [31:0] br_target, jmp_target, imem_rdata;
  logic        imem_req, instr_valid, misalign;
  logic [31:0] imem_addr, instr, pc, epc;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .exc         (exc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .epc         (epc),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, br, jmp, exc, ack;
    logic [31:0] br_t, jmp_t, rdata;
    logic        e_req, e_valid, e_mis;
    logic [31:0] e_pc, e_instr, e_epc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, s, b, input logic [31:0] bt,
                             input logic j, input logic [31:0] jt,
                             input logic e, a, input logic [31:0] rd,
                             input logic req, vld, mis,
                             input logic [31:0] p, ins, ep);
    vec_t t;
    t.rst = r; t.stall = s; t.br = b; t.br_t = bt; t.jmp = j; t.jmp_t = jt;
    t.exc = e; t.ack = a; t.rdata = rd;
    t.e_req = req; t.e_valid = vld; t.e_mis = mis;
    t.e_pc = p; t.e_instr = ins; t.e_epc = ep;
    return t;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, s, b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt,
                       input logic e, a, input logic [31:0] rd);
    rst = r; stall = s; br_taken = b; br_target = bt; jmp = j;
    jmp_target = jt; exc = e; imem_ack = a; imem_rdata = rd;
  endtask

  initial begin
    bit got_valid;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    //                rst stl br br_t          jmp jmp_t         exc ack rdata          req vld mis pc             instr          epc
    vecs.push_back(v(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h00400000, 32'h0,        32'h0));
    vecs.push_back(v(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h00400000, 32'h0,        32'h0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h00400000, 32'h0,        32'h0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hA0A0A0A0, 0, 1, 0, 32'h00400000, 32'hA0A0A0A0, 32'h0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h00400004, 32'hA0A0A0A0, 32'h0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hA1A1A1A1, 0, 1, 0, 32'h00400004, 32'hA1A1A1A1, 32'h0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h00400008, 32'hA1A1A1A1, 32'h0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hA2A2A2A2, 0, 1, 0, 32'h00400008, 32'hA2A2A2A2, 32'h0));
    // stalled ISSUE: stray ack and branch must be ignored
    vecs.push_back(v(0, 1, 1, 32'h00400100, 0, 32'h0,        0, 1, 32'hDEADDEAD, 0, 1, 0, 32'h00400008, 32'hA2A2A2A2, 32'h0));
    vecs.push_back(v(0, 1, 0, 32'h0,        1, 32'h00401002, 0, 1, 32'hDEADDEAD, 0, 1, 0, 32'h00400008, 32'hA2A2A2A2, 32'h0));
    vecs.push_back(v(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 32'h00400008, 32'hA2A2A2A2, 32'h0));
    // jump beats branch, misaligned jump target
    vecs.push_back(v(0, 0, 1, 32'h00400100, 1, 32'h00401002, 0, 0, 32'h0,        1, 0, 1, 32'h00401000, 32'hA2A2A2A2, 32'h0));
    vecs.push_back(v(0, 0, 1, 32'h00500000, 1, 32'h00600000, 0, 0, 32'h0,        1, 0, 0, 32'h00401000, 32'hA2A2A2A2, 32'h0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hB0B0B0B0, 0, 1, 0, 32'h00401000, 32'hB0B0B0B0, 32'h0));
    vecs.push_back(v(0, 0, 1, 32'h00400011, 0, 32'h0,        0, 0, 32'h0,        1, 0, 1, 32'h00400010, 32'hB0B0B0B0, 32'h0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h00400010, 32'hB0B0B0B0, 32'h0));
    // exception in FETCH with same-cycle ack
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'hBADBADBA, 1, 0, 0, 32'h80000180, 32'hB0B0B0B0, 32'h00400010));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h80000180, 32'hB0B0B0B0, 32'h00400010));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hC0C0C0C0, 0, 1, 0, 32'h80000180, 32'hC0C0C0C0, 32'h00400010));
    // exception beats stall and jump in ISSUE
    vecs.push_back(v(0, 1, 0, 32'h0,        1, 32'h12345678, 1, 0, 32'h0,        1, 0, 0, 32'h80000180, 32'hC0C0C0C0, 32'h80000180));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hC1C1C1C1, 0, 1, 0, 32'h80000180, 32'hC1C1C1C1, 32'h80000180));
    vecs.push_back(v(0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 0, 32'h0,        1, 0, 0, 32'hFFFFFFFC, 32'hC1C1C1C1, 32'h80000180));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hC2C2C2C2, 0, 1, 0, 32'hFFFFFFFC, 32'hC2C2C2C2, 32'h80000180));
    // pc+4 wraps
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h00000000, 32'hC2C2C2C2, 32'h80000180));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h00000000, 32'hC2C2C2C2, 32'h80000180));
    // reset mid-FETCH overrides exc and ack
    vecs.push_back(v(1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'hD0D0D0D0, 0, 0, 0, 32'h00400000, 32'h0,        32'h0));
    // exc and ack in BOOT ignored
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'hD1D1D1D1, 1, 0, 0, 32'h00400000, 32'h0,        32'h0));
    vecs.push_back(v(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hE0E0E0E0, 0, 1, 0, 32'h00400000, 32'hE0E0E0E0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].br_t, vecs[i].jmp,
            vecs[i].jmp_t, vecs[i].exc, vecs[i].ack, vecs[i].rdata);
      step();
      check("imem_req",    i, {31'b0, imem_req},    {31'b0, vecs[i].e_req});
      check("instr_valid", i, {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      check("misalign",    i, {31'b0, misalign},    {31'b0, vecs[i].e_mis});
      check("pc",          i, pc,        vecs[i].e_pc);
      check("imem_addr",   i, imem_addr, vecs[i].e_pc);
      check("instr",       i, instr,     vecs[i].e_instr);
      check("epc",         i, epc,       vecs[i].e_epc);
    end

    // Sequence: release ISSUE, request must appear the next cycle, then a slow ack.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("seq_release_req", 100, {31'b0, imem_req}, 32'd1);
    check("seq_release_pc",  100, pc, 32'h00400004);
    for (int k = 0; k < 3; k++) begin
      step();
      check("seq_wait_req", 101 + k, {31'b0, imem_req}, 32'd1);
      check("seq_wait_vld", 101 + k, {31'b0, instr_valid}, 32'd0);
    end
    drive(0, 1, 0, 0, 0, 0, 0, 1, 32'hF0F0F0F0);
    got_valid = 1'b0;
    for (int k = 0; k < 4 && !got_valid; k++) begin
      step();
      imem_ack = 1'b0;
      got_valid = instr_valid;
    end
    n_cmp++;
    if (!got_valid) begin
      n_err++;
      $display("FAIL seq_ack_timeout step 104: got instr_valid 0 want 1 within 4 cycles");
    end
    check("seq_instr", 105, instr, 32'hF0F0F0F0);
    check("seq_req_issue", 105, {31'b0, imem_req}, 32'd0);

    // Sequence: exc beats an unstalled misaligned jump; no misalign pulse.
    drive(0, 0, 1, 32'h00700001, 1, 32'h00700003, 1, 0, 0);
    step();
    check("seq_exc_pc",  106, pc,  32'h80000180);
    check("seq_exc_epc", 106, epc, 32'h00400004);
    check("seq_exc_mis", 106, {31'b0, misalign}, 32'd0);
    check("seq_exc_req", 106, {31'b0, imem_req}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 32'h00400000, SHALL be the PC value loaded by reset.
REQ-002 Parameter EXC_VEC, default 32'h80000180, SHALL be the PC value loaded on exception.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on posedge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 stall  in  1  SHALL be the pipeline hold request; freezes PC while in ISSUE.
REQ-006 br_taken  in  1  SHALL be the taken-branch redirect strobe.
REQ-007 br_target  in  32  SHALL be the branch target address.
REQ-008 jmp  in  1  SHALL be the jump redirect strobe.
REQ-009 jmp_target  in  32  SHALL be the jump target address.
REQ-010 exc  in  1  SHALL be the exception strobe, valid in any state.
REQ-011 imem_req  out  1  SHALL be the instruction-memory read request.
REQ-012 imem_addr  out  32  SHALL be the fetch address, always equal to pc.
REQ-013 imem_ack  in  1  SHALL be the memory completion strobe, qualifying imem_rdata.
REQ-014 imem_rdata  in  32  SHALL be the returned instruction word.
REQ-015 instr  out  32  SHALL be the registered fetched instruction.
REQ-016 instr_valid  out  1  SHALL flag instr as valid for decode.
REQ-017 pc  out  32  SHALL be the current fetch PC.
REQ-018 epc  out  32  SHALL be the PC captured at the last exception.
REQ-019 misalign  out  1  SHALL be a one-cycle pulse on a redirect target with bits [1:0] != 0.

Function
REQ-020 The FSM SHALL have exactly three states: BOOT, FETCH and ISSUE.
REQ-021 BOOT SHALL last exactly one cycle, driving imem_req=0 and instr_valid=0, then go to FETCH.
REQ-022 FETCH SHALL drive imem_req=1 and imem_addr=pc, and stay until imem_ack=1.
REQ-023 On an imem_ack cycle in FETCH, the block SHALL register imem_rdata into instr, set instr_valid=1 and go to ISSUE the next cycle.
REQ-024 imem_ack outside FETCH SHALL be ignored.
REQ-025 ISSUE SHALL drive instr_valid=1 and imem_req=0.
REQ-026 In ISSUE with stall=1 and no exc, the block SHALL hold pc, instr and state.
REQ-027 In ISSUE with stall=0, pc SHALL load next_pc, instr_valid SHALL clear and the state SHALL become FETCH.
REQ-028 next_pc priority SHALL be: jmp -> jmp_target, else br_taken -> br_target, else pc+4.
REQ-029 Redirect targets SHALL have bits [1:0] forced to 0; misalign SHALL pulse in the same cycle when the raw bits are nonzero.
REQ-030 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-031 br_taken and jmp SHALL be sampled only in ISSUE with stall=0 and ignored otherwise.
REQ-032 exc in any non-BOOT state SHALL, in one cycle: set epc<=pc, pc<=EXC_VEC, instr_valid<=0, state<=FETCH, and abort any outstanding fetch.
REQ-033 exc SHALL take priority over stall, jmp and br_taken.
REQ-034 exc in BOOT SHALL be ignored.
REQ-035 After an aborted fetch, the first imem_ack accepted SHALL be for the new address (an ack arriving in the abort cycle is dropped).
REQ-036 The latency from the ISSUE release to the next imem_req SHALL be 1 cycle.
REQ-037 The minimum instruction period SHALL be 2 cycles (FETCH with immediate ack, then ISSUE).

Reset
REQ-038 rst=1 SHALL, on posedge, set state=BOOT, pc=RESET_VEC, epc=0, instr=0, instr_valid=0 and misalign=0; imem_req SHALL be 0 during reset.
REQ-039 rst SHALL override all other inputs, including exc, and a fetch in progress SHALL be abandoned.

Structure
REQ-040 A shared package SHALL hold the state encoding (BOOT/FETCH/ISSUE), the default RESET_VEC and EXC_VEC constants, and the PC increment constant 4.
REQ-041 The next-PC priority selection and alignment logic SHALL be one combinational sub-module, pc_next_sel.

Verification
REQ-042 Reset then ack every FETCH cycle: pc SHALL step 0x00400000 -> 0x00400004 -> 0x00400008, and instr_valid SHALL be high every 2nd cycle.
REQ-043 ISSUE with stall=1 for 3 cycles at pc=0x00400008: pc, instr and instr_valid=1 SHALL hold, with no imem_req.
REQ-044 ISSUE with br_taken=1, br_target=0x00400100, jmp=1, jmp_target=0x00401002: next pc SHALL be 0x00401000, misalign SHALL pulse and the branch SHALL be ignored.
REQ-045 exc during FETCH at pc=0x00400010 with ack delayed: epc SHALL be 0x00400010, pc 0x80000180, a same-cycle ack SHALL be ignored and a new imem_req SHALL be issued at 0x80000180.
REQ-046 pc=0xFFFFFFFC, no redirect: the next pc SHALL be 0x00000000.
REQ-047 rst asserted mid-FETCH: the next cycle SHALL be BOOT with pc=0x00400000 and imem_req=0.
